// File: rtl/mm_pkg.sv
// mm_pkg: shared widths, solver state encoding and history entry layout for the Mastermind solver
package mm_pkg;
  localparam int DIGIT_W = 3;
  localparam int NUM_POS = 4;
  localparam int CODE_W = 12;
  localparam int FB_W = 3;
  localparam int HIST_W = CODE_W + 2 * FB_W;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SEARCH = 3'd1;
  localparam logic [2:0] PRESENT = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] FAIL = 3'd4;
  typedef struct packed {
    logic [CODE_W-1:0] guess;
    logic [FB_W-1:0] red;
    logic [FB_W-1:0] white;
  } hist_t;
endpackage

// File: rtl/mm_score.sv
// mm_score: combinational Mastermind scorer; code/guess (12b, digit 1 in [2:0]) in, red/white (3b) out
module mm_score
  import mm_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic [CODE_W-1:0] guess,
  output logic [FB_W-1:0]   red,
  output logic [FB_W-1:0]   white
);
  logic [FB_W-1:0] common;
  function automatic logic [FB_W-1:0] cnt(input logic [CODE_W-1:0] v, input logic [DIGIT_W-1:0] c);
    cnt = '0;
    for (int p = 0; p < NUM_POS; p++) cnt = cnt + FB_W'(v[p*DIGIT_W+:DIGIT_W] == c);
  endfunction
  always_comb begin
    red = '0;
    common = '0;
    for (int p = 0; p < NUM_POS; p++)
      red = red + FB_W'(code[p*DIGIT_W+:DIGIT_W] == guess[p*DIGIT_W+:DIGIT_W]);
    for (int c = 0; c < (1 << DIGIT_W); c++)
      common = common + ((cnt(code, DIGIT_W'(c)) < cnt(guess, DIGIT_W'(c))) ? cnt(code, DIGIT_W'(c)) : cnt(guess, DIGIT_W'(c)));
  end
  assign white = common - red;
endmodule

// File: rtl/mastermind_solver.sv
// mastermind_solver: consistent-candidate codebreaker; clock/resetn/start/feedback_valid/red_in/white_in in, guess_out/guess_valid/busy/solved/fail/guess_count out
module mastermind_solver
  import mm_pkg::*;
#(
  parameter int MAX_GUESSES = 8,
  parameter int NUM_COLORS = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              feedback_valid,
  input  logic [FB_W-1:0]   red_in,
  input  logic [FB_W-1:0]   white_in,
  output logic [CODE_W-1:0] guess_out,
  output logic              guess_valid,
  output logic              busy,
  output logic              solved,
  output logic              fail,
  output logic [3:0]        guess_count
);
  localparam int IW = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1;
  localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(NUM_COLORS - 1);
  logic [2:0] state;
  logic [CODE_W-1:0] cand;
  logic [3:0] k, hist_count;
  hist_t hist [MAX_GUESSES];
  hist_t cur;
  logic [FB_W-1:0] s_red, s_white;
  function automatic logic [CODE_W-1:0] next_code(input logic [CODE_W-1:0] c);
    logic carry;
    carry = 1'b1;
    next_code = c;
    for (int p = 0; p < NUM_POS; p++)
      if (carry) begin
        if (c[p*DIGIT_W+:DIGIT_W] == TOP) next_code[p*DIGIT_W+:DIGIT_W] = '0;
        else begin
          next_code[p*DIGIT_W+:DIGIT_W] = c[p*DIGIT_W+:DIGIT_W] + 1'b1;
          carry = 1'b0;
        end
      end
  endfunction
  function automatic logic is_last(input logic [CODE_W-1:0] c);
    is_last = c == {NUM_POS{TOP}};
  endfunction
  assign cur = hist[k[IW-1:0]];
  assign busy = state == SEARCH;
  mm_score u_score (
    .code (cand),
    .guess(cur.guess),
    .red  (s_red),
    .white(s_white)
  );
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      cand <= '0;
      k <= '0;
      hist_count <= '0;
      guess_out <= '0;
      guess_valid <= 1'b0;
      solved <= 1'b0;
      fail <= 1'b0;
      guess_count <= '0;
    end else if (start) begin
      state <= SEARCH;
      cand <= '0;
      k <= '0;
      hist_count <= '0;
      guess_valid <= 1'b0;
      solved <= 1'b0;
      fail <= 1'b0;
      guess_count <= '0;
    end else if (state == SEARCH) begin
      if (k == hist_count) begin
        guess_out <= cand;
        guess_count <= guess_count + 1'b1;
        guess_valid <= 1'b1;
        state <= PRESENT;
      end else if (s_red == cur.red && s_white == cur.white) k <= k + 1'b1;
      else if (is_last(cand)) begin
        fail <= 1'b1;
        state <= FAIL;
      end else begin
        cand <= next_code(cand);
        k <= '0;
      end
    end else if (state == PRESENT && feedback_valid) begin
      guess_valid <= 1'b0;
      if (red_in == 3'd4) begin
        solved <= 1'b1;
        state <= DONE;
      end else begin
        hist[hist_count[IW-1:0]] <= '{guess: guess_out, red: red_in, white: white_in};
        hist_count <= hist_count + 1'b1;
        if (guess_count == 4'(MAX_GUESSES) || is_last(guess_out)) begin
          fail <= 1'b1;
          state <= FAIL;
        end else begin
          cand <= next_code(guess_out);
          k <= '0;
          state <= SEARCH;
        end
      end
    end
  end
endmodule

// File: tb/tb_mastermind_solver.sv
// tb_mastermind_solver: directed and table-driven checks of the solver and its scorer
module tb_mastermind_solver;
  logic clock = 1'b0, resetn = 1'b0, start = 1'b0, feedback_valid = 1'b0;
  logic [2:0] red_in = '0, white_in = '0;
  logic [11:0] go [3];
  logic gv [3], bz [3], sol [3], fl [3];
  logic [3:0] gc [3];
  logic [11:0] sc_code, sc_guess;
  logic [2:0] sc_red, sc_white;
  int tests = 0, fails = 0;
  typedef struct { logic [11:0] code, guess; logic [2:0] red, white; } sc_vec_t;
  typedef struct { logic [11:0] guess; logic [2:0] red, white; } step_t;
  sc_vec_t stab [8];
  step_t steps [5];
  always #5 clock = ~clock;
  mastermind_solver #(.MAX_GUESSES(8), .NUM_COLORS(8)) d8 (
    .clock(clock), .resetn(resetn), .start(start), .feedback_valid(feedback_valid),
    .red_in(red_in), .white_in(white_in), .guess_out(go[0]), .guess_valid(gv[0]),
    .busy(bz[0]), .solved(sol[0]), .fail(fl[0]), .guess_count(gc[0]));
  mastermind_solver #(.MAX_GUESSES(2), .NUM_COLORS(8)) d2 (
    .clock(clock), .resetn(resetn), .start(start), .feedback_valid(feedback_valid),
    .red_in(red_in), .white_in(white_in), .guess_out(go[1]), .guess_valid(gv[1]),
    .busy(bz[1]), .solved(sol[1]), .fail(fl[1]), .guess_count(gc[1]));
  mastermind_solver #(.MAX_GUESSES(15), .NUM_COLORS(6)) d6 (
    .clock(clock), .resetn(resetn), .start(start), .feedback_valid(feedback_valid),
    .red_in(red_in), .white_in(white_in), .guess_out(go[2]), .guess_valid(gv[2]),
    .busy(bz[2]), .solved(sol[2]), .fail(fl[2]), .guess_count(gc[2]));
  mm_score u_ref (.code(sc_code), .guess(sc_guess), .red(sc_red), .white(sc_white));
  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task automatic fb(input logic [2:0] r, input logic [2:0] w);
    red_in = r;
    white_in = w;
    feedback_valid = 1'b1;
    tick;
    feedback_valid = 1'b0;
  endtask
  task automatic wait_guess(input int d, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (gv[d]) begin
        ok = 1'b1;
        break;
      end
      if (fl[d]) break;
      tick;
    end
  endtask
  task automatic zeros(input int d, input string tag);
    chk({tag, " guess_out"}, 32'(go[d]), 0);
    chk({tag, " guess_valid"}, 32'(gv[d]), 0);
    chk({tag, " busy"}, 32'(bz[d]), 0);
    chk({tag, " solved"}, 32'(sol[d]), 0);
    chk({tag, " fail"}, 32'(fl[d]), 0);
    chk({tag, " guess_count"}, 32'(gc[d]), 0);
  endtask
  function automatic void score(input logic [11:0] c, input logic [11:0] g, output int r, output int w);
    int cc [8];
    int gg [8];
    int m;
    r = 0;
    m = 0;
    for (int i = 0; i < 8; i++) begin
      cc[i] = 0;
      gg[i] = 0;
    end
    for (int p = 0; p < 4; p++) begin
      if (c[p*3+:3] == g[p*3+:3]) r++;
      cc[c[p*3+:3]]++;
      gg[g[p*3+:3]]++;
    end
    for (int i = 0; i < 8; i++) m += (cc[i] < gg[i]) ? cc[i] : gg[i];
    w = m - r;
  endfunction
  initial begin
    bit ok;
    int n, gvs, r, w;
    logic [11:0] secret;
    logic [11:0] hg [16];
    int hr [16], hw [16];
    stab[0] = '{12'h000, 12'h000, 3'd4, 3'd0};
    stab[1] = '{12'h200, 12'h001, 3'd2, 3'd2};
    stab[2] = '{12'h8D1, 12'h29C, 3'd0, 3'd4};
    stab[3] = '{12'h8D1, 12'hAD1, 3'd3, 3'd0};
    stab[4] = '{12'h240, 12'h009, 3'd0, 3'd4};
    stab[5] = '{12'hFFF, 12'h000, 3'd0, 3'd0};
    stab[6] = '{12'h489, 12'h651, 3'd1, 3'd2};
    stab[7] = '{12'h005, 12'hB68, 3'd0, 3'd2};
    steps[0] = '{12'h000, 3'd3, 3'd0};
    steps[1] = '{12'h001, 3'd2, 3'd2};
    steps[2] = '{12'h008, 3'd2, 3'd2};
    steps[3] = '{12'h040, 3'd2, 3'd2};
    steps[4] = '{12'h200, 3'd4, 3'd0};
    for (int i = 0; i < 8; i++) begin
      sc_code = stab[i].code;
      sc_guess = stab[i].guess;
      #1;
      chk($sformatf("score red %0d", i), 32'(sc_red), 32'(stab[i].red));
      chk($sformatf("score white %0d", i), 32'(sc_white), 32'(stab[i].white));
    end
    tick;
    tick;
    zeros(0, "reset");
    resetn = 1'b1;
    tick;
    pulse_start;
    chk("first edge guess_valid", 32'(gv[0]), 0);
    chk("first edge busy", 32'(bz[0]), 1);
    tick;
    chk("first guess_valid", 32'(gv[0]), 1);
    chk("first guess_out", 32'(go[0]), 0);
    fb(3'd4, 3'd0);
    chk("win solved", 32'(sol[0]), 1);
    chk("win guess_count", 32'(gc[0]), 1);
    chk("win guess_valid", 32'(gv[0]), 0);
    pulse_start;
    for (int i = 0; i < 5; i++) begin
      wait_guess(0, 10000, ok);
      chk($sformatf("s200 guess %0d arrived", i), 32'(ok), 1);
      chk($sformatf("s200 guess %0d", i), 32'(go[0]), 32'(steps[i].guess));
      fb(steps[i].red, steps[i].white);
    end
    chk("s200 solved", 32'(sol[0]), 1);
    chk("s200 guess_count", 32'(gc[0]), 5);
    pulse_start;
    wait_guess(0, 100, ok);
    chk("impossible first guess", 32'(ok), 1);
    fb(3'd0, 3'd1);
    n = 0;
    gvs = 0;
    while (!fl[0] && n < 6000) begin
      tick;
      n++;
      if (gv[0]) gvs++;
    end
    chk("impossible fail", 32'(fl[0]), 1);
    chk("impossible scan cycles", 32'(n), 4095);
    chk("impossible no guesses", 32'(gvs), 0);
    chk("impossible guess_count", 32'(gc[0]), 1);
    pulse_start;
    wait_guess(1, 100, ok);
    chk("max2 guess 1", 32'(go[1]), 0);
    fb(3'd0, 3'd0);
    wait_guess(1, 10000, ok);
    chk("max2 guess 2 arrived", 32'(ok), 1);
    chk("max2 guess 2", 32'(go[1]), 32'h249);
    chk("max2 count 2", 32'(gc[1]), 2);
    fb(3'd0, 3'd0);
    chk("max2 fail", 32'(fl[1]), 1);
    chk("max2 final count", 32'(gc[1]), 2);
    chk("max2 guess_valid", 32'(gv[1]), 0);
    chk("max2 solved", 32'(sol[1]), 0);
    pulse_start;
    wait_guess(0, 100, ok);
    fb(3'd0, 3'd0);
    tick;
    tick;
    tick;
    chk("mid busy", 32'(bz[0]), 1);
    fb(3'd4, 3'd0);
    chk("feedback in search ignored", 32'(sol[0]), 0);
    resetn = 1'b0;
    tick;
    zeros(0, "mid reset");
    resetn = 1'b1;
    tick;
    pulse_start;
    wait_guess(0, 100, ok);
    fb(3'd0, 3'd0);
    tick;
    tick;
    tick;
    chk("restart busy", 32'(bz[0]), 1);
    pulse_start;
    chk("restart guess_valid", 32'(gv[0]), 0);
    chk("restart count", 32'(gc[0]), 0);
    tick;
    chk("restart guess_valid up", 32'(gv[0]), 1);
    chk("restart guess_out", 32'(go[0]), 0);
    chk("restart count 1", 32'(gc[0]), 1);
    start = 1'b1;
    red_in = 3'd4;
    feedback_valid = 1'b1;
    tick;
    start = 1'b0;
    feedback_valid = 1'b0;
    chk("start beats feedback solved", 32'(sol[0]), 0);
    chk("start beats feedback count", 32'(gc[0]), 0);
    for (int g = 0; g < 16; g++) begin
      secret = '0;
      for (int p = 0; p < 4; p++) secret[p*3+:3] = 3'($urandom_range(0, 5));
      pulse_start;
      n = 0;
      while (1) begin
        bit legal, cons;
        wait_guess(2, 20000, ok);
        if (!ok) begin
          chk($sformatf("nc6 game %0d guess arrived", g), 32'(ok), 1);
          break;
        end
        legal = 1'b1;
        for (int p = 0; p < 4; p++) if (go[2][p*3+:3] > 3'd5) legal = 1'b0;
        chk($sformatf("nc6 game %0d legal %0h", g, go[2]), 32'(legal), 1);
        cons = 1'b1;
        for (int j = 0; j < n; j++) begin
          score(go[2], hg[j], r, w);
          if (r != hr[j] || w != hw[j]) cons = 1'b0;
        end
        chk($sformatf("nc6 game %0d consistent %0h", g, go[2]), 32'(cons), 1);
        score(secret, go[2], r, w);
        hg[n] = go[2];
        hr[n] = r;
        hw[n] = w;
        n++;
        fb(3'(r), 3'(w));
        if (r == 4 || n >= 15) break;
      end
      chk($sformatf("nc6 game %0d solved secret %0h", g, secret), 32'(sol[2]), 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
